// File: rtl/emib_seq_pkg.sv
// Shared types for the EMIB/AIB channel bring-up sequencer: FSM encoding and
// error-code values reported on err_code.
package emib_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CAL    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_TIMEOUT = 2'b01;
  localparam err_code_t ERR_LOSS    = 2'b10;

  localparam int ERR_CH_W = 5;

endpackage

// File: rtl/emib_ch_bringup_seq_if.sv
// Control/status bundle between the bring-up sequencer (slave side) and the
// top-level logic that starts it and owns the channel calibration feedback.
interface emib_ch_bringup_seq_if
  import emib_seq_pkg::*;
#(
  parameter int NUM_CH = 24
);

  logic                start;
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   ch_cal_done;
  logic [NUM_CH-1:0]   ch_rstn;
  logic [NUM_CH-1:0]   ch_cal_req;
  logic [NUM_CH-1:0]   ch_up;
  logic                busy;
  logic                done;
  logic                error;
  err_code_t           err_code;
  logic [ERR_CH_W-1:0] err_ch;

  modport master (
    output start, ch_en, ch_cal_done,
    input  ch_rstn, ch_cal_req, ch_up, busy, done, error, err_code, err_ch
  );

  modport slave (
    input  start, ch_en, ch_cal_done,
    output ch_rstn, ch_cal_req, ch_up, busy, done, error, err_code, err_ch
  );

endinterface

// File: rtl/emib_lsb_enc.sv
// Lowest-set-bit encoder: vld flags any bit set, idx is the lowest set position.
module emib_lsb_enc #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  vec,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        vld = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/emib_ch_bringup_seq.sv
// Brings EMIB/AIB channels up one at a time (reset release, settle, calibrate)
// and then watches the up channels for loss of calibration.
module emib_ch_bringup_seq
  import emib_seq_pkg::*;
#(
  parameter int NUM_CH  = 24,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input logic                  clk,
  input logic                  rst,
  emib_ch_bringup_seq_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [NUM_CH-1:0]   mask, mask_nx;
  logic [TO_W-1:0]     cnt, cnt_nx;
  logic [NUM_CH-1:0]   rstn, rstn_nx;
  logic [NUM_CH-1:0]   cal_req, cal_req_nx;
  logic [NUM_CH-1:0]   up, up_nx;
  err_code_t           err_code, err_code_nx;
  logic [ERR_CH_W-1:0] err_ch, err_ch_nx;

  logic [NUM_CH-1:0]   sel;
  logic [NUM_CH-1:0]   loss_vec;
  logic [NUM_CH-1:0]   loss_sel;
  logic                loss_vld;
  logic [ERR_CH_W-1:0] loss_idx;

  function automatic logic [ERR_CH_W-1:0] ch_of(input logic [IDX_W-1:0] i);
    return ERR_CH_W'(i);
  endfunction

  // idx == NUM_CH shifts the bit out entirely, so sel is zero once scanning ends.
  assign sel      = ONE << idx;
  assign loss_vec = up & ~bus.ch_cal_done;
  assign loss_sel = ONE << loss_idx;

  emib_lsb_enc #(
    .N  (NUM_CH),
    .IW (ERR_CH_W)
  ) u_loss_enc (
    .vec (loss_vec),
    .vld (loss_vld),
    .idx (loss_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      mask     <= '0;
      cnt      <= '0;
      rstn     <= '0;
      cal_req  <= '0;
      up       <= '0;
      err_code <= ERR_NONE;
      err_ch   <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      mask     <= mask_nx;
      cnt      <= cnt_nx;
      rstn     <= rstn_nx;
      cal_req  <= cal_req_nx;
      up       <= up_nx;
      err_code <= err_code_nx;
      err_ch   <= err_ch_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    mask_nx     = mask;
    cnt_nx      = cnt;
    rstn_nx     = rstn;
    cal_req_nx  = cal_req;
    up_nx       = up;
    err_code_nx = err_code;
    err_ch_nx   = err_ch;

    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // A restart takes priority over loss detection in DONE.
        if (bus.start) begin
          state_nx    = ST_SCAN;
          idx_nx      = '0;
          mask_nx     = bus.ch_en;
          cnt_nx      = '0;
          rstn_nx     = '0;
          cal_req_nx  = '0;
          up_nx       = '0;
          err_code_nx = ERR_NONE;
          err_ch_nx   = '0;
        end else if (state == ST_DONE && loss_vld) begin
          state_nx    = ST_ERR;
          err_code_nx = ERR_LOSS;
          err_ch_nx   = loss_idx;
          up_nx       = up & ~loss_sel;
        end
      end

      ST_SCAN: begin
        if (idx == IDX_W'(NUM_CH)) begin
          state_nx = ST_DONE;
        end else if (|(mask & sel)) begin
          state_nx = ST_SETTLE;
          cnt_nx   = TO_W'(1);
          rstn_nx  = rstn | sel;
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end

      ST_SETTLE: begin
        if (cnt == TO_W'(SETTLE)) begin
          state_nx   = ST_CAL;
          cnt_nx     = TO_W'(1);
          cal_req_nx = sel;
        end else begin
          cnt_nx = cnt + TO_W'(1);
        end
      end

      ST_CAL: begin
        // cal_done is checked first so a completion on the last allowed
        // cycle still counts as success.
        if (|(bus.ch_cal_done & sel)) begin
          state_nx   = ST_SCAN;
          up_nx      = up | sel;
          cal_req_nx = '0;
          idx_nx     = idx + IDX_W'(1);
          cnt_nx     = '0;
        end else if (cnt == TO_W'(TIMEOUT)) begin
          state_nx    = ST_ERR;
          err_code_nx = ERR_TIMEOUT;
          err_ch_nx   = ch_of(idx);
          rstn_nx     = rstn & ~sel;
          cal_req_nx  = '0;
          cnt_nx      = '0;
        end else begin
          cnt_nx = cnt + TO_W'(1);
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.ch_rstn    = rstn;
  assign bus.ch_cal_req = cal_req;
  assign bus.ch_up      = up;
  assign bus.busy       = (state == ST_SCAN) || (state == ST_SETTLE) || (state == ST_CAL);
  assign bus.done       = (state == ST_DONE);
  assign bus.error      = (state == ST_ERR);
  assign bus.err_code   = err_code;
  assign bus.err_ch     = err_ch;

endmodule

// File: tb/tb_emib_ch_bringup_seq.sv
// Bench for emib_ch_bringup_seq: a cal_done responder plus an event scoreboard
// of expected rising edges (ch_rstn, ch_cal_req, done, error) with their cycles.
module tb_emib_ch_bringup_seq;
  import emib_seq_pkg::*;

  localparam int NUM_CH  = 24;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 1000;

  // kind: 0 ch_rstn rise, 1 ch_cal_req rise, 2 done rise, 3 error rise; cyc -1 = any
  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t               exp_q[$];
  int                resp_dly[NUM_CH];
  int                age[NUM_CH];
  logic [NUM_CH-1:0] resp_done;
  logic [NUM_CH-1:0] drop_mask;

  emib_ch_bringup_seq_if #(.NUM_CH(NUM_CH)) bus();

  emib_ch_bringup_seq #(
    .NUM_CH  (NUM_CH),
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT),
    .TO_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic sb_monitor();
    logic [NUM_CH-1:0] p_rstn, p_req;
    logic p_done, p_err;
    ev_t obs[$];
    ev_t e;
    p_rstn = '0; p_req = '0; p_done = 1'b0; p_err = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_cal_req[i]) age[i]++;
        else age[i] = 0;
        if (resp_dly[i] >= 0 && age[i] >= resp_dly[i] + 1) resp_done[i] = 1'b1;
      end
      bus.ch_cal_done = resp_done & ~drop_mask;
      obs.delete();
      for (int i = 0; i < NUM_CH; i++)
        if (bus.ch_rstn[i] && !p_rstn[i]) obs.push_back('{i, 0, cyc});
      for (int i = 0; i < NUM_CH; i++)
        if (bus.ch_cal_req[i] && !p_req[i]) obs.push_back('{i, 1, cyc});
      if (bus.done && !p_done) obs.push_back('{-1, 2, cyc});
      if (bus.error && !p_err) obs.push_back('{-1, 3, cyc});
      foreach (obs[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got ch=%0d kind=%0d cyc=%0d required no event",
                   obs[k].ch, obs[k].kind, obs[k].cyc);
        end else begin
          e = exp_q.pop_front();
          if (obs[k].ch != e.ch || obs[k].kind != e.kind || (e.cyc >= 0 && obs[k].cyc != e.cyc)) begin
            errors++;
            $display("FAIL sb_event got ch=%0d kind=%0d cyc=%0d required ch=%0d kind=%0d cyc=%0d",
                     obs[k].ch, obs[k].kind, obs[k].cyc, e.ch, e.kind, e.cyc);
          end
        end
      end
      p_rstn = bus.ch_rstn;
      p_req  = bus.ch_cal_req;
      p_done = bus.done;
      p_err  = bus.error;
    end
  endtask

  // Called at a negedge; t is the cycle in which start is presented.
  task automatic do_start(input logic [NUM_CH-1:0] en, output int t);
    bus.start = 1'b1;
    bus.ch_en = en;
    t = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    resp_done = '0;
    drop_mask = '0;
    for (int i = 0; i < NUM_CH; i++) age[i] = 0;
  endtask

  // Contiguous channels 0..n-1, each answered dly cycles after its request.
  task automatic push_chain(input int t, input int n, input int dly, input bit with_done);
    int per;
    per = 1 + SETTLE + dly + 1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{k, 0, t + 2 + per * k});
      exp_q.push_back('{k, 1, t + 2 + SETTLE + per * k});
    end
    if (with_done) exp_q.push_back('{-1, 2, t + 1 + per * n + (NUM_CH - n) + 1});
  endtask

  task automatic wait_sig(input int which, input int max, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < max && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = bus.done | bus.error;
        1:       hit = bus.error;
        default: hit = 1'b0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ch_rstn, bus.ch_cal_req, bus.ch_up} !== '0) begin
      errors++; $display("FAIL reset_ch got=%h required=0", {bus.ch_rstn, bus.ch_cal_req, bus.ch_up});
    end
    checks++;
    if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b required=000", {bus.busy, bus.done, bus.error});
    end
    checks++;
    if ({bus.err_code, bus.err_ch} !== 7'd0) begin
      errors++; $display("FAIL reset_err got=%h required=0", {bus.err_code, bus.err_ch});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.error} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got=%b required=000", {bus.busy, bus.done, bus.error});
    end
  endtask

  task automatic test_two_ch();
    int t;
    bit hit;
    for (int i = 0; i < NUM_CH; i++) resp_dly[i] = 3;
    do_start(24'h000003, t);
    push_chain(t, 2, 3, 1'b1);
    wait_sig(0, 200, hit);
    checks++;
    if (!hit) begin errors++; $display("FAIL two_ch_wait got=timeout required=done"); end
    checks++;
    if (bus.ch_up !== 24'h3 || bus.ch_rstn !== 24'h3) begin
      errors++; $display("FAIL two_ch_up got up=%h rstn=%h required up=3 rstn=3", bus.ch_up, bus.ch_rstn);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0 || bus.ch_cal_req !== '0) begin
      errors++; $display("FAIL two_ch_status got done=%b error=%b busy=%b req=%h required 1 0 0 0",
                         bus.done, bus.error, bus.busy, bus.ch_cal_req);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL two_ch_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int t;
    bit hit;
    resp_dly[2] = -1;
    do_start(24'h000004, t);
    exp_q.push_back('{2, 0, t + 4});
    exp_q.push_back('{2, 1, t + 12});
    exp_q.push_back('{-1, 3, t + 12 + TIMEOUT});
    wait_sig(1, 1200, hit);
    checks++;
    if (!hit) begin errors++; $display("FAIL timeout_wait got=timeout required=error"); end
    checks++;
    if (bus.err_code !== ERR_TIMEOUT || bus.err_ch !== 5'd2) begin
      errors++; $display("FAIL timeout_code got code=%b ch=%0d required code=01 ch=2", bus.err_code, bus.err_ch);
    end
    checks++;
    if (bus.ch_rstn !== '0 || bus.ch_up !== '0 || bus.ch_cal_req !== '0) begin
      errors++; $display("FAIL timeout_ch got rstn=%h up=%h req=%h required 0 0 0",
                         bus.ch_rstn, bus.ch_up, bus.ch_cal_req);
    end
    checks++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL timeout_status got error=%b done=%b required 1 0", bus.error, bus.done);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_timeout_edge();
    int t;
    bit hit;
    resp_dly[0] = TIMEOUT - 1;
    do_start(24'h000001, t);
    checks++;
    if (bus.err_code !== ERR_NONE || bus.err_ch !== 5'd0 || bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear got code=%b ch=%0d error=%b busy=%b required 00 0 0 1",
                         bus.err_code, bus.err_ch, bus.error, bus.busy);
    end
    push_chain(t, 1, TIMEOUT - 1, 1'b1);
    wait_sig(0, 1200, hit);
    checks++;
    if (!hit) begin errors++; $display("FAIL edge_wait got=timeout required=done"); end
    checks++;
    if (bus.ch_up !== 24'h1 || bus.done !== 1'b1 || bus.error !== 1'b0 || bus.err_code !== ERR_NONE) begin
      errors++; $display("FAIL edge_result got up=%h done=%b error=%b code=%b required 1 1 0 00",
                         bus.ch_up, bus.done, bus.error, bus.err_code);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL edge_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_loss();
    int t;
    bit hit;
    for (int i = 0; i < NUM_CH; i++) resp_dly[i] = 3;
    do_start(24'h00000F, t);
    push_chain(t, 4, 3, 1'b1);
    wait_sig(0, 200, hit);
    checks++;
    if (!hit || bus.ch_up !== 24'hF) begin
      errors++; $display("FAIL loss_setup got up=%h hit=%b required up=f hit=1", bus.ch_up, hit);
    end
    exp_q.push_back('{-1, 3, -1});
    drop_mask = 24'h00000A;
    wait_sig(1, 10, hit);
    checks++;
    if (!hit || bus.err_code !== ERR_LOSS || bus.err_ch !== 5'd1) begin
      errors++; $display("FAIL loss_code got code=%b ch=%0d required code=10 ch=1", bus.err_code, bus.err_ch);
    end
    checks++;
    if (bus.ch_up !== 24'h0D || bus.ch_rstn !== 24'hF) begin
      errors++; $display("FAIL loss_ch got up=%h rstn=%h required up=d rstn=f", bus.ch_up, bus.ch_rstn);
    end
    checks++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL loss_status got error=%b done=%b required 1 0", bus.error, bus.done);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL loss_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_empty();
    int t;
    bit hit;
    do_start('0, t);
    push_chain(t, 0, 3, 1'b1);
    wait_sig(0, 60, hit);
    checks++;
    if (!hit || bus.done !== 1'b1 || bus.error !== 1'b0) begin
      errors++; $display("FAIL empty_done got done=%b error=%b required 1 0", bus.done, bus.error);
    end
    checks++;
    if (bus.ch_cal_req !== '0 || bus.ch_rstn !== '0 || bus.ch_up !== '0) begin
      errors++; $display("FAIL empty_ch got req=%h rstn=%h up=%h required 0 0 0",
                         bus.ch_cal_req, bus.ch_rstn, bus.ch_up);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL empty_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_rst_abort();
    int t;
    bit hit;
    bit pulse;
    for (int i = 0; i < NUM_CH; i++) resp_dly[i] = 3;
    resp_dly[5] = -1;
    do_start(24'h00003F, t);
    push_chain(t, 5, 3, 1'b0);
    exp_q.push_back('{5, 0, t + 2 + 65});
    exp_q.push_back('{5, 1, t + 2 + SETTLE + 65});
    hit = 1'b0;
    for (int n = 0; n < 150 && !hit; n++) begin
      @(negedge clk);
      pulse = (cyc == t + 12) || (cyc == t + 30) || (cyc == t + 40);
      bus.start = pulse;
      bus.ch_en = pulse ? 24'h000000 : 24'h00003F;
      if (bus.ch_cal_req[5]) hit = 1'b1;
    end
    bus.start = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach_ch5 got=timeout required=cal_req[5]"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ch_rstn, bus.ch_cal_req, bus.ch_up} !== '0 || {bus.busy, bus.done, bus.error} !== 3'b000) begin
      errors++; $display("FAIL abort_clear got ch=%h st=%b required 0 000",
                         {bus.ch_rstn, bus.ch_cal_req, bus.ch_up}, {bus.busy, bus.done, bus.error});
    end
    checks++;
    if (bus.err_code !== ERR_NONE || bus.err_ch !== 5'd0) begin
      errors++; $display("FAIL abort_err got code=%b ch=%0d required 00 0", bus.err_code, bus.err_ch);
    end
    rst = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_pending got=%0d required=0", exp_q.size()); end
    @(negedge clk);
    do_start(24'h000003, t);
    push_chain(t, 2, 3, 1'b1);
    wait_sig(0, 200, hit);
    checks++;
    if (!hit || bus.ch_up !== 24'h3 || bus.done !== 1'b1) begin
      errors++; $display("FAIL rerun got up=%h done=%b required up=3 done=1", bus.ch_up, bus.done);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rerun_pending got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.ch_en       = '0;
    bus.ch_cal_done = '0;
    resp_done       = '0;
    drop_mask       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      resp_dly[i] = -1;
      age[i]      = 0;
    end
    fork
      sb_monitor();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    test_two_ch();
    test_timeout();
    test_timeout_edge();
    test_loss();
    test_empty();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
